line_centroid_ci: RTL

//  Custom-instruction co-processor consuming the per-line averaging words produced by the camera

---
 rtl/line_centroid_ci.sv | 109 ++++++++++
 1 files changed

// File: rtl/line_centroid_ci.sv
// line_centroid_ci: per-line centroid custom instruction with a restoring divider and frame accumulators
module line_centroid_ci #(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int         FRAC_BITS           = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone
);
  localparam int W = 20 + FRAC_BITS;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] dividend;
  logic [W-1:0] quotient;
  logic [12:0]  remainder;
  logic [11:0]  divisor;
  logic [4:0]   stepCount;
  logic [31:0]  centroidSum;
  logic [15:0]  validLines;

  logic        isMyCi;
  logic        idleCi;
  logic        immDone;
  logic        finishDone;
  logic        startDivide;
  logic [1:0]  opCode;
  logic [11:0] opCount;
  logic [31:0] quotExt;
  logic [23:0] quot24;
  logic [12:0] remShift;
  logic        remFits;
  logic [32:0] sumNext;
  logic        unusedBits;

  assign opCode      = ciValueA[1:0];
  assign opCount     = ciValueB[11:0];
  assign isMyCi      = reset & ciStart & ciCke & (ciN == customInstructionId);
  assign idleCi      = isMyCi & (state == IDLE);
  // Reads, clear and the divide-by-zero case all complete in their start cycle
  assign immDone     = idleCi & ((opCode != 2'd0) | (opCount == 12'd0));
  assign startDivide = idleCi & (opCode == 2'd0) & (opCount != 12'd0);
  assign finishDone  = reset & ciCke & (state == FINISH);
  assign quotExt     = 32'(quotient);
  assign quot24      = quotExt[23:0];
  assign remShift    = {remainder[11:0], dividend[W-1]};
  assign remFits     = remShift >= {1'b0, divisor};
  assign sumNext     = {1'b0, centroidSum} + {9'd0, quot24};
  assign unusedBits  = ^{ciValueA[31:2], quotExt[31:24], remainder[12]};

  // Completion strobe and result mux; result is forced to zero whenever no completion is signalled
  always_comb begin
    ciDone   = immDone | finishDone;
    ciResult = finishDone        ? {8'd0, quot24} :
               !immDone          ? 32'd0 :
               opCode == 2'd1    ? centroidSum :
               opCode == 2'd2    ? {16'd0, validLines} :
               opCode == 2'd3    ? 32'd0 : 32'h8000_0000;
  end

  // Control FSM, one restoring divide step per enabled cycle, and saturating frame accumulators
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      dividend    <= '0;
      quotient    <= '0;
      remainder   <= '0;
      divisor     <= '0;
      stepCount   <= '0;
      centroidSum <= '0;
      validLines  <= '0;
    end else if (ciCke) begin
      if (state == IDLE) begin
        if (startDivide) begin
          dividend  <= {ciValueB[31:12], {FRAC_BITS{1'b0}}};
          divisor   <= opCount;
          remainder <= '0;
          quotient  <= '0;
          stepCount <= 5'(W - 1);
          state     <= DIVIDE;
        end
        if (idleCi && opCode == 2'd3) begin
          centroidSum <= '0;
          validLines  <= '0;
        end
      end else if (state == DIVIDE) begin
        remainder <= remFits ? remShift - {1'b0, divisor} : remShift;
        quotient  <= {quotient[W-2:0], remFits};
        dividend  <= {dividend[W-2:0], 1'b0};
        stepCount <= stepCount - 5'd1;
        state     <= (stepCount == 5'd0) ? FINISH : DIVIDE;
      end else if (state == FINISH) begin
        centroidSum <= sumNext[32] ? 32'hFFFF_FFFF : sumNext[31:0];
        validLines  <= (validLines == 16'hFFFF) ? validLines : validLines + 16'd1;
        state       <= IDLE;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
